// File: rtl/shift_seq.sv
// shift_seq: multi-cycle 8-bit shift unit. It works through large shift amounts
// in steps of at most 7 positions, then presents one registered result per
// accepted request.
//
// Build option: SHIFT_SEQ_ROR_EN. When it is defined, OPCODE 11 rotates right.
// When it is undefined, no rotate logic is built, and OPCODE 11 passes DATA
// through after the zero-amount latency.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESET   in   asynchronous active-high reset
//   START   in   request strobe, sampled only while idle
//   OPCODE  in   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   DATA    in   8-bit operand, sampled with START
//   AMOUNT  in   8-bit unsigned shift amount, sampled with START
//   RESULT  out  registered result, valid while DONE, held until the next completion
//   BUSY    out  high while shift steps are in progress
//   DONE    out  one-cycle completion pulse
module shift_seq (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] OPCODE,
    input  logic [7:0] DATA,
    input  logic [7:0] AMOUNT,
    output logic [7:0] RESULT,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t     state, state_nx;
    logic [1:0] op;
    logic [7:0] work;
    logic [3:0] rem;
    logic [3:0] eff;
    logic [2:0] step;
    logic [3:0] rem_nx;

    // One bounded step (0..7 positions) of the latched shift kind.
    function automatic logic [7:0] shift_step(input logic [1:0] kind,
                                              input logic [7:0] w,
                                              input logic [2:0] n);
        case (kind)
            2'b00:   return w << n;
            2'b01:   return w >> n;
            2'b10:   return 8'($signed(w) >>> n);
`ifdef SHIFT_SEQ_ROR_EN
            2'b11:   return (w >> n) | (w << (4'd8 - {1'b0, n}));
`endif
            default: return w;
        endcase
    endfunction

    // Effective amount. For non-rotate kinds, any amount of 8 or more already
    // gives the fully saturated value, so the amount is clamped to 8. That
    // bounds the work to two steps.
    always_comb begin
        eff = 4'd0;
        if (OPCODE == 2'b11) begin
`ifdef SHIFT_SEQ_ROR_EN
            eff = {1'b0, AMOUNT[2:0]};
`else
            eff = 4'd0;
`endif
        end else begin
            eff = (AMOUNT >= 8'd8) ? 4'd8 : AMOUNT[3:0];
        end
    end

    assign step   = (rem > 4'd7) ? 3'd7 : rem[2:0];
    assign rem_nx = rem - {1'b0, step};

    // Next-state logic and the busy output.
    always_comb begin
        state_nx = state;
        BUSY     = 1'b0;
        case (state)
            IDLE:    if (START) state_nx = (eff != 4'd0) ? SHIFT : FIN;
            SHIFT: begin
                BUSY = 1'b1;
                if (rem_nx == 4'd0) state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            op     <= 2'b00;
            work   <= 8'h00;
            rem    <= 4'd0;
            RESULT <= 8'h00;
            DONE   <= 1'b0;
        end else begin
            state <= state_nx;
            // Result and completion pulse are registered out of FIN. They
            // appear together in the cycle after FIN.
            DONE  <= (state == FIN);
            if (state == FIN) RESULT <= work;
            case (state)
                IDLE: if (START) begin
                    op   <= OPCODE;
                    work <= DATA;
                    rem  <= eff;
                end
                SHIFT: begin
                    work <= shift_step(op, work, step);
                    rem  <= rem_nx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [1:0] OPCODE = 2'b00;
    logic [7:0] DATA = 8'h00;
    logic [7:0] AMOUNT = 8'h00;
    logic [7:0] RESULT;
    logic       BUSY;
    logic       DONE;

    shift_seq dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE),
        .DATA(DATA), .AMOUNT(AMOUNT), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] res;
        int         lat;   // edges from accept to DONE visible
        int         acc;   // edge number of accept
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compares every DONE against the scoreboard. It also checks
    // that RESULT holds between completions and that BUSY and DONE never
    // overlap.
    initial begin : monitor
        logic [7:0] last_res;
        int         busy_cnt;
        exp_t       e;
        last_res = 8'h00;
        busy_cnt = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                last_res = 8'h00;
                busy_cnt = 0;
            end else begin
                if (BUSY || DONE) begin
                    n_checks++;
                    if (BUSY && DONE) begin
                        n_fail++;
                        $display("FAIL busy_done_overlap: BUSY=%b DONE=%b required not both", BUSY, DONE);
                    end
                end
                if (BUSY) busy_cnt++;
                if (DONE) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_done: DONE=1 with RESULT=%h, none pending", RESULT);
                    end else begin
                        e = sb.pop_front();
                        if (RESULT !== e.res) begin
                            n_fail++;
                            $display("FAIL %s result: got %h required %h", e.name, RESULT, e.res);
                        end
                        n_checks++;
                        if (cyc - e.acc != e.lat) begin
                            n_fail++;
                            $display("FAIL %s latency: got %0d required %0d", e.name, cyc - e.acc, e.lat);
                        end
                        n_checks++;
                        if (busy_cnt != e.lat - 1) begin
                            n_fail++;
                            $display("FAIL %s busy_cycles: got %0d required %0d", e.name, busy_cnt, e.lat - 1);
                        end
                        last_res = e.res;
                    end
                    busy_cnt = 0;
                end else begin
                    n_checks++;
                    if (RESULT !== last_res) begin
                        n_fail++;
                        $display("FAIL result_hold: got %h required %h", RESULT, last_res);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Waits for the scoreboard to drain. A bounded wait counts as a failure.
    task automatic drain(input string name);
        int k;
        for (k = 0; k < 12; k++) begin
            @(posedge CLK);
            if (sb.size() == 0) break;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d pending required 0", name, sb.size());
            sb.delete();
        end
        @(posedge CLK);
    endtask

    // Issues one request while the DUT is idle and waits for its completion.
    task automatic issue(input string name, input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] amt, input logic [7:0] res, input int lat);
        exp_t e;
        @(negedge CLK);
        OPCODE = op; DATA = d; AMOUNT = amt; START = 1'b1;
        e.res = res; e.lat = lat; e.acc = cyc + 1; e.name = name;
        sb.push_back(e);
        @(posedge CLK);
        #1 START = 1'b0;
        drain(name);
    endtask

    initial begin : driver
        exp_t e;
        int   base;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_result", RESULT, 8'h00);
        check("reset_busy", {7'b0, BUSY}, 8'h00);
        check("reset_done", {7'b0, DONE}, 8'h00);
        @(negedge CLK) RESET = 1'b0;

        // Basic shifts and zero amount
        issue("sll_0f_3",   2'b00, 8'h0F, 8'd3,   8'h78, 2);
        issue("srl_f0_5",   2'b01, 8'hF0, 8'd5,   8'h07, 2);
        issue("srl_5a_0",   2'b01, 8'h5A, 8'd0,   8'h5A, 1);
        issue("sra_90_2",   2'b10, 8'h90, 8'd2,   8'hE4, 2);
        issue("srl_ff_7",   2'b01, 8'hFF, 8'd7,   8'h01, 2);
        // Saturation: two shift steps, 7 then 1
        issue("sra_80_200", 2'b10, 8'h80, 8'd200, 8'hFF, 3);
        issue("sra_7f_9",   2'b10, 8'h7F, 8'd9,   8'h00, 3);
        issue("sll_ff_8",   2'b00, 8'hFF, 8'd8,   8'h00, 3);
        issue("srl_c3_255", 2'b01, 8'hC3, 8'd255, 8'h00, 3);
`ifdef SHIFT_SEQ_ROR_EN
        issue("ror_01_9",   2'b11, 8'h01, 8'd9,   8'h80, 2);
        issue("ror_a5_8",   2'b11, 8'hA5, 8'd8,   8'hA5, 1);
        issue("ror_96_3",   2'b11, 8'h96, 8'd3,   8'hD2, 2);
`else
        issue("ror_off_01_3", 2'b11, 8'h01, 8'd3, 8'h01, 1);
`endif
        issue("sra_c1_4",   2'b10, 8'hC1, 8'd4,   8'hFC, 2);

        // Reset while shifting: the request is dropped with no DONE, and
        // RESULT (0xFC before) clears.
        @(negedge CLK);
        OPCODE = 2'b00; DATA = 8'h81; AMOUNT = 8'd12; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        check("midop_busy", {7'b0, BUSY}, 8'h01);
        #1 RESET = 1'b1;
        #1;
        check("midop_reset_result", RESULT, 8'h00);
        check("midop_reset_busy", {7'b0, BUSY}, 8'h00);
        check("midop_reset_done", {7'b0, DONE}, 8'h00);
        @(posedge CLK);
        #2 RESET = 1'b0;
        repeat (6) @(posedge CLK);
        issue("post_reset_sll_81_1", 2'b00, 8'h81, 8'd1, 8'h02, 2);

        // START held high with operands alternating each cycle. Accepts can
        // happen only in idle cycles, at edges base+0,3,6,9. The even
        // offsets take set A and the odd offsets take set B.
        @(negedge CLK);
        base = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            e.res  = (i % 2 == 0) ? 8'h78 : 8'h07;
            e.lat  = 2;
            e.acc  = base + 3 * i;
            e.name = (i % 2 == 0) ? "held_a" : "held_b";
            sb.push_back(e);
        end
        START = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                OPCODE = 2'b00; DATA = 8'h0F; AMOUNT = 8'd3;
            end else begin
                OPCODE = 2'b01; DATA = 8'hF0; AMOUNT = 8'd5;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        drain("held_start");
        repeat (4) @(posedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
